param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO. It succeeds the fixed sync_fifo and adds configurable width and depth, including non-power-of-2 depths. It also adds an occupancy count, programmable almost-full/almost-empty thresholds, same-cycle read+write when full, and sticky overflow/underflow error flags. It sits between producer/consumer datapath stages that share one clock.

---
 rtl/param_sync_fifo_if.sv | 27 ++
 rtl/param_sync_fifo.sv | 62 ++++++
 tb/tb_param_sync_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: producer/consumer handshake and status bundle for param_sync_fifo
interface param_sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             wn;
  logic             rn;
  logic             err_clr;
  logic [WIDTH-1:0] DATAIN;
  logic [WIDTH-1:0] DATAOUT;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output wn, rn, err_clr, DATAIN,
    input  DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wn, rn, err_clr, DATAIN,
    output DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO of any depth with occupancy count, thresholds and sticky error flags
module param_sync_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input logic              clock,
  input logic              reset,
  param_sync_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_udf;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;
  assign w_full   = r_count == CW'(DEPTH);
  assign w_empty  = r_count == '0;
  assign w_rd_ok  = bus.rn && !w_empty;
  assign w_wr_ok  = bus.wn && (!w_full || w_rd_ok);
  assign w_wr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
  assign w_rd_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
  // storage array, deliberately left unreset
  always_ff @(posedge clock)
    if (w_wr_ok) r_mem[r_wr_ptr] <= bus.DATAIN;
  // pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ok ? w_wr_nxt : r_wr_ptr;
      r_rd_ptr <= w_rd_ok ? w_rd_nxt : r_rd_ptr;
      r_dout   <= w_rd_ok ? r_mem[r_rd_ptr] : r_dout;
      r_count  <= (w_wr_ok && !w_rd_ok) ? r_count + CW'(1) :
                  (w_rd_ok && !w_wr_ok) ? r_count - CW'(1) : r_count;
      r_ovf    <= (bus.wn && !w_wr_ok) ? 1'b1 : bus.err_clr ? 1'b0 : r_ovf;
      r_udf    <= (bus.rn && w_empty)  ? 1'b1 : bus.err_clr ? 1'b0 : r_udf;
    end
  assign bus.DATAOUT      = r_dout;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = r_count >= CW'(AF_LEVEL);
  assign bus.almost_empty = r_count <= CW'(AE_LEVEL);
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for param_sync_fifo at depth 8 and depth 5
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] m_dout = '0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  param_sync_fifo_if #(.WIDTH(32), .DEPTH(8)) b8();
  param_sync_fifo_if #(.WIDTH(8),  .DEPTH(5)) b5();
  param_sync_fifo #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u8 (.clock(clk), .reset(rst_n), .bus(b8));
  param_sync_fifo #(.WIDTH(8),  .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) u5 (.clock(clk), .reset(rst_n), .bus(b5));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic chk_all(input bit sel);
    int dep = sel ? 5 : 8;
    int af = sel ? 3 : 6;
    int n = sb.size();
    chk("count",        sel ? 32'(b5.count)   : 32'(b8.count), 32'(n));
    chk("dataout",      sel ? 32'(b5.DATAOUT) : b8.DATAOUT, m_dout);
    chk("full",         32'(sel ? b5.full : b8.full), 32'(n == dep));
    chk("empty",        32'(sel ? b5.empty : b8.empty), 32'(n == 0));
    chk("almost_full",  32'(sel ? b5.almost_full : b8.almost_full), 32'(n >= af));
    chk("almost_empty", 32'(sel ? b5.almost_empty : b8.almost_empty), 32'(n <= 1));
    chk("overflow",     32'(sel ? b5.overflow : b8.overflow), 32'(m_ovf));
    chk("underflow",    32'(sel ? b5.underflow : b8.underflow), 32'(m_udf));
  endtask
  task automatic op(input bit sel, input logic w, input logic r, input logic [31:0] d, input logic clr);
    int dep = sel ? 5 : 8;
    bit rd_ok, wr_ok;
    rd_ok = r && sb.size() != 0;
    wr_ok = w && (sb.size() != dep || rd_ok);
    if (rd_ok) m_dout = sb.pop_front();
    if (wr_ok) sb.push_back(sel ? {24'd0, d[7:0]} : d);
    m_ovf = (w && !wr_ok) ? 1'b1 : clr ? 1'b0 : m_ovf;
    m_udf = (r && !rd_ok) ? 1'b1 : clr ? 1'b0 : m_udf;
    if (sel) begin
      b5.wn = w; b5.rn = r; b5.DATAIN = d[7:0]; b5.err_clr = clr;
    end else begin
      b8.wn = w; b8.rn = r; b8.DATAIN = d; b8.err_clr = clr;
    end
    @(posedge clk);
    #1;
    b8.wn = 0; b8.rn = 0; b8.err_clr = 0;
    b5.wn = 0; b5.rn = 0; b5.err_clr = 0;
    chk_all(sel);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] fill [8] = '{10, 15, 20, 30, 35, 40, 45, 50};
    int max5 = 0;
    b8.wn = 0; b8.rn = 0; b8.err_clr = 0; b8.DATAIN = '0;
    b5.wn = 0; b5.rn = 0; b5.err_clr = 0; b5.DATAIN = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(0);
    chk_all(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all(0);
    foreach (fill[i]) op(0, 1, 0, fill[i], 0);
    chk("full_after_fill", 32'(b8.full), 1);
    op(0, 1, 0, 32'd77, 0);
    chk("ovf_9th_write", 32'(b8.overflow), 1);
    op(0, 1, 0, 32'd78, 1);
    chk("ovf_set_beats_clr", 32'(b8.overflow), 1);
    op(0, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(b8.overflow), 0);
    op(0, 1, 1, 32'd99, 0);
    chk("simul_full_oldest", b8.DATAOUT, 32'd10);
    chk("simul_full_count", 32'(b8.count), 8);
    repeat (8) op(0, 0, 1, 0, 0);
    chk("drain_last_is_99", b8.DATAOUT, 32'd99);
    op(0, 0, 1, 0, 0);
    chk("udf_read_empty", 32'(b8.underflow), 1);
    chk("udf_dout_held", b8.DATAOUT, 32'd99);
    op(0, 0, 0, 0, 1);
    chk("udf_cleared", 32'(b8.underflow), 0);
    op(0, 1, 1, 32'd5, 0);
    chk("simul_empty_count", 32'(b8.count), 1);
    chk("simul_empty_udf", 32'(b8.underflow), 1);
    op(0, 0, 1, 0, 1);
    chk("simul_empty_word", b8.DATAOUT, 32'd5);
    for (int i = 1; i <= 4; i++) op(0, 1, 0, 32'(i), 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_dout = '0; m_ovf = 0; m_udf = 0;
    chk_all(0);
    #2;
    rst_n = 1'b1;
    op(0, 1, 0, 32'd7, 0);
    op(0, 0, 1, 0, 0);
    chk("post_reset_read", b8.DATAOUT, 32'd7);
    sb.delete();
    m_dout = '0; m_ovf = 0; m_udf = 0;
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 3; i++) begin
        op(1, 1, 0, 32'(rep * 3 + i + 1), 0);
        if (32'(b5.count) > max5) max5 = 32'(b5.count);
      end
      for (int i = 0; i < 3; i++) op(1, 0, 1, 0, 0);
      chk("wrap_last_word", 32'(b5.DATAOUT), 32'(rep * 3 + 3));
    end
    chk("wrap_max_count", 32'(max5), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
